// File: rtl/e_mdu_if.sv
// E-stage <-> multiply/divide unit handshake bundle.
// Master is the E stage; slave is the MDU.
interface e_mdu_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  mdu_sel;
  logic        start;
  logic        busy;
  logic [31:0] mdu_out;

  modport master (
    output a, b, mdu_sel, start,
    input  busy, mdu_out
  );

  modport slave (
    input  a, b, mdu_sel, start,
    output busy, mdu_out
  );
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle MIPS-style multiply/divide unit with HI/LO registers.
// Optional madd/maddu/msub/msubu support is enabled by MDU_MADD_EN.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave bus
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_hi_tmp;
  logic [31:0] r_lo_tmp;

  logic               w_launch;
  logic               w_div;
  logic [63:0]        w_res;
  logic [63:0]        w_acc;
  logic [63:0]        w_pu;
  logic signed [63:0] w_sa64;
  logic signed [63:0] w_sb64;
  logic signed [63:0] w_ps;
  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;
  logic signed [31:0] w_sq;
  logic signed [31:0] w_sr;
  logic               w_ovf;
  logic               w_bz;
  logic [31:0]        w_out;

  assign w_acc  = {r_hi, r_lo};
  assign w_sa   = bus.a;
  assign w_sb   = bus.b;
  assign w_sa64 = {{32{bus.a[31]}}, bus.a};
  assign w_sb64 = {{32{bus.b[31]}}, bus.b};
  assign w_ps   = w_sa64 * w_sb64;
  assign w_pu   = {32'd0, bus.a} * {32'd0, bus.b};
  assign w_sq   = w_sa / w_sb;
  assign w_sr   = w_sa % w_sb;
  assign w_bz   = (bus.b == 32'd0);
  assign w_ovf  = (bus.a == 32'h8000_0000) &&
                  (bus.b == 32'hFFFF_FFFF);

  // Divide by zero reloads the current HI/LO so commit is a no-op.
  always_comb begin
    w_launch = 1'b0;
    w_div    = 1'b0;
    w_res    = 64'd0;
    case (bus.mdu_sel)
      4'd1: begin
        w_launch = 1'b1;
        w_res    = w_ps;
      end
      4'd2: begin
        w_launch = 1'b1;
        w_res    = w_pu;
      end
      4'd3: begin
        w_launch = 1'b1;
        w_div    = 1'b1;
        if (w_bz)
          w_res = w_acc;
        else if (w_ovf)
          w_res = {32'd0, 32'h8000_0000};
        else
          w_res = {w_sr, w_sq};
      end
      4'd4: begin
        w_launch = 1'b1;
        w_div    = 1'b1;
        if (w_bz)
          w_res = w_acc;
        else
          w_res = {bus.a % bus.b, bus.a / bus.b};
      end
`ifdef MDU_MADD_EN
      4'd9: begin
        w_launch = 1'b1;
        w_res    = w_acc + w_ps;
      end
      4'd10: begin
        w_launch = 1'b1;
        w_res    = w_acc + w_pu;
      end
      4'd11: begin
        w_launch = 1'b1;
        w_res    = w_acc - w_ps;
      end
      4'd12: begin
        w_launch = 1'b1;
        w_res    = w_acc - w_pu;
      end
`else
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 16'd0;
      r_busy   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_hi_tmp <= 32'd0;
      r_lo_tmp <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start && w_launch) begin
            r_hi_tmp <= w_res[63:32];
            r_lo_tmp <= w_res[31:0];
            r_cnt    <= w_div ? 16'(DIV_CYCLES)
                              : 16'(MULT_CYCLES);
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else if (!bus.start) begin
            if (bus.mdu_sel == 4'd5)
              r_hi <= bus.a;
            else if (bus.mdu_sel == 4'd6)
              r_lo <= bus.a;
          end
        end
        S_RUN: begin
          if (r_cnt <= 16'd1) begin
            r_hi    <= r_hi_tmp;
            r_lo    <= r_lo_tmp;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_out = 32'd0;
    if (bus.mdu_sel == 4'd7)
      w_out = r_hi;
    else if (bus.mdu_sel == 4'd8)
      w_out = r_lo;
  end

  assign bus.busy    = r_busy;
  assign bus.mdu_out = w_out;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: busy-pulse lengths and HI/LO reads
// are queued by the stimulus and checked by an independent monitor.
module tb_e_mdu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rd_chk = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int run = 0;

  int          q_busy[$];
  logic [31:0] q_rd[$];
  logic [3:0]  q_sel[$];

  e_mdu_if u_if ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u_if.busy) begin
      run++;
    end else if (run != 0) begin
      n_vec++;
      if (q_busy.size() == 0) begin
        n_err++;
        $display("FAIL busy_len: unexpected pulse of %0d cycles", run);
      end else begin
        int e;
        e = q_busy.pop_front();
        if (run != e) begin
          n_err++;
          $display("FAIL busy_len: got %0d cycles, want %0d", run, e);
        end
      end
      run = 0;
    end
    if (rd_chk) begin
      n_vec++;
      if (q_rd.size() == 0) begin
        n_err++;
        $display("FAIL mdu_out: read with empty scoreboard");
      end else begin
        logic [31:0] e;
        logic [3:0] s;
        e = q_rd.pop_front();
        s = q_sel.pop_front();
        if (u_if.mdu_out !== e) begin
          n_err++;
          $display("FAIL mdu_out sel=%0d: got %h, want %h",
                   s, u_if.mdu_out, e);
        end
      end
    end
  end

  task automatic op(input logic [3:0] s,
                    input logic [31:0] x, input logic [31:0] y);
    u_if.mdu_sel = s;
    u_if.a = x;
    u_if.b = y;
    u_if.start = 1'b1;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    u_if.mdu_sel = 4'd0;
  endtask

  task automatic mt(input logic [3:0] s, input logic [31:0] x);
    u_if.mdu_sel = s;
    u_if.a = x;
    @(posedge clk);
    #1;
    u_if.mdu_sel = 4'd0;
  endtask

  task automatic rd(input logic [3:0] s, input logic [31:0] e);
    u_if.mdu_sel = s;
    q_rd.push_back(e);
    q_sel.push_back(s);
    rd_chk = 1'b1;
    @(posedge clk);
    #1;
    rd_chk = 1'b0;
    u_if.mdu_sel = 4'd0;
  endtask

  task automatic rdhl(input logic [31:0] h, input logic [31:0] l);
    rd(4'd7, h);
    rd(4'd8, l);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    u_if.a = 32'd0;
    u_if.b = 32'd0;
    u_if.mdu_sel = 4'd0;
    u_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rdhl(32'd0, 32'd0);

    // mult -2*3; HI read mid-run shows old value
    op(4'd1, 32'hFFFF_FFFE, 32'd3);
    q_busy.push_back(5);
    rd(4'd7, 32'd0);
    idle(4);
    rdhl(32'hFFFF_FFFF, 32'hFFFF_FFFA);

    op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    q_busy.push_back(5);
    idle(5);
    rdhl(32'hFFFF_FFFE, 32'h0000_0001);

    op(4'd1, 32'h8000_0000, 32'h8000_0000);
    q_busy.push_back(5);
    idle(5);
    rdhl(32'h4000_0000, 32'h0000_0000);

    op(4'd4, 32'd7, 32'd2);
    q_busy.push_back(10);
    idle(10);
    rdhl(32'd1, 32'd3);

    op(4'd3, 32'hFFFF_FFF9, 32'd2);
    q_busy.push_back(10);
    idle(10);
    rdhl(32'hFFFF_FFFF, 32'hFFFF_FFFD);

    op(4'd3, 32'd7, 32'hFFFF_FFFE);
    q_busy.push_back(10);
    idle(10);
    rdhl(32'd1, 32'hFFFF_FFFD);

    op(4'd4, 32'hFFFF_FFFF, 32'd10);
    q_busy.push_back(10);
    idle(10);
    rdhl(32'd5, 32'h1999_9999);

    // divide by zero keeps HI/LO
    mt(4'd5, 32'h11);
    mt(4'd6, 32'h22);
    rdhl(32'h11, 32'h22);
    op(4'd3, 32'd5, 32'd0);
    q_busy.push_back(10);
    idle(10);
    rdhl(32'h11, 32'h22);

    mt(4'd5, 32'd0);
    mt(4'd6, 32'd1);
`ifdef MDU_MADD_EN
    op(4'd12, 32'd1, 32'd2);
    q_busy.push_back(5);
    idle(5);
    rdhl(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op(4'd10, 32'd1, 32'd1);
    q_busy.push_back(5);
    idle(5);
    rdhl(32'd0, 32'd0);
    op(4'd9, 32'hFFFF_FFFF, 32'd2);
    q_busy.push_back(5);
    idle(5);
    rdhl(32'hFFFF_FFFF, 32'hFFFF_FFFE);
`else
    op(4'd12, 32'd1, 32'd2);
    idle(5);
    rdhl(32'd0, 32'd1);
    op(4'd9, 32'd3, 32'd4);
    idle(5);
    rdhl(32'd0, 32'd1);
`endif

    // start with non-launch codes is ignored
    mt(4'd5, 32'h1234);
    mt(4'd6, 32'h5678);
    op(4'd7, 32'd1, 32'd2);
    op(4'd13, 32'd1, 32'd2);
    op(4'd5, 32'hDEAD, 32'd2);
    op(4'd0, 32'd1, 32'd2);
    idle(2);
    rdhl(32'h1234, 32'h5678);

    mt(4'd5, 32'hABCD);
    rd(4'd7, 32'hABCD);

    // second start and mthi during RUN are ignored
    op(4'd1, 32'd3, 32'd4);
    q_busy.push_back(5);
    idle(1);
    op(4'd3, 32'd100, 32'd7);
    mt(4'd5, 32'hDEAD);
    idle(2);
    rdhl(32'd0, 32'd12);

    // reset in the 3rd busy cycle aborts the mult
    mt(4'd5, 32'h55);
    op(4'd1, 32'd7, 32'd9);
    q_busy.push_back(2);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    rdhl(32'd0, 32'd0);
    reset = 1'b0;
    op(4'd2, 32'd2, 32'd3);
    q_busy.push_back(5);
    idle(5);
    rdhl(32'd0, 32'd6);

    idle(3);
    n_vec++;
    if (q_busy.size() != 0 || q_rd.size() != 0) begin
      n_err++;
      $display("FAIL drain: busy_q=%0d rd_q=%0d left, want 0 0",
               q_busy.size(), q_rd.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: E_MDU

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration in cycles for multiply-class operations.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration in cycles for divide-class operations.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port a, input, 32: rs operand from the E stage.
REQ-006 Port b, input, 32: rt operand from the E stage.
REQ-007 Port mdu_sel, input, 4: operation code. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 madd, 10 maddu, 11 msub, 12 msubu; 13-15 are treated as none.
REQ-008 Port start, input, 1: one-cycle pulse that launches a mult, div or madd-class operation.
REQ-009 Port busy, output, 1: computation in progress; used by the hazard unit to stall.
REQ-010 Port mdu_out, output, 32: HI when mdu_sel=7, LO when mdu_sel=8, otherwise 0; purely combinational from the registered HI/LO.

Function
REQ-011 The block SHALL use FSM states IDLE and RUN, a cycle counter, and shadow registers hi_tmp/lo_tmp alongside the architectural HI/LO registers.
REQ-012 In IDLE, start=1 with a launch code SHALL compute the result into hi_tmp/lo_tmp from a/b sampled that edge, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-013 Busy timing: busy=1 from the cycle after start for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), then 0.
REQ-014 Commit: on the edge that ends RUN, HI<=hi_tmp and LO<=lo_tmp, and the state returns to IDLE; HI/LO are new in the first cycle busy=0.
REQ-015 mult/multu: {HI,LO} = 64-bit signed/unsigned product.
REQ-016 div/divu: LO = quotient and HI = remainder, signed (truncate toward zero, remainder takes the dividend's sign) or unsigned.
REQ-017 Divide by zero: b=0 SHALL still run the full DIV_CYCLES busy period, with HI/LO left unchanged at commit.
REQ-018 madd/maddu: {HI,LO} <= {HI,LO} + product; msub/msubu: {HI,LO} <= {HI,LO} - product; signedness follows the opcode; mod 2^64 wraparound; the HI/LO value used is the one present at start; uses MULT_CYCLES.
REQ-019 mthi/mtlo: write a into HI/LO at the next edge, with no busy, when state is IDLE and start=0.
REQ-020 start or mt* while RUN (or while busy) SHALL be ignored; the hazard unit guarantees this does not occur, and the bench checks that it is ignored.
REQ-021 start=1 with a non-launch mdu_sel SHALL be ignored.
REQ-022 mdu_out during RUN SHALL show the old HI/LO.

Reset
REQ-023 reset=1 SHALL immediately set HI=0, LO=0, hi_tmp=0, lo_tmp=0, counter=0, state=IDLE and busy=0, regardless of clk.
REQ-024 Reset during RUN SHALL abort the operation with no commit; the first start after release SHALL behave normally.

Configuration
REQ-025 Macro MDU_MADD_EN defined: codes 9-12 are supported as in REQ-018.
REQ-026 MDU_MADD_EN undefined: codes 9-12 are treated as none; start with them does not assert busy, and HI/LO are unchanged.

Verification
REQ-027 mult a=0xFFFFFFFE, b=3, start -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mfhi/mflo output these values.
REQ-028 divu a=7, b=2 -> busy for 10 cycles; then LO=3, HI=1. div a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-029 HI=0, LO=1, then msubu a=1, b=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF. Without MDU_MADD_EN: busy=0 and HI/LO=0/1 unchanged.
REQ-030 div a=5, b=0 with prior HI=0x11, LO=0x22 -> busy for 10 cycles; HI=0x11, LO=0x22 after.
REQ-031 mult launched, reset pulsed in the 3rd busy cycle -> busy=0 and HI=LO=0 immediately; a following multu 2x3 yields LO=6.
REQ-032 mthi a=0xABCD in IDLE -> mfhi=0xABCD the next cycle; a second start during RUN is ignored and does not extend busy.
